tpu_host_sequencer: RTL and testbench

//  Bus initiator that drives the TPU's r_w/addr/dataIn/dataOut slave port.

---
 rtl/tpu_seq_pkg.sv | 38 +++
 rtl/tpu_seq_out_reg.sv | 32 +++
 rtl/tpu_host_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_tpu_host_sequencer.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_seq_pkg.sv
// tpu_seq_pkg: TPU slave address map, sequencer FSM states and
// words-per-row helpers shared by the host sequencer files.
package tpu_seq_pkg;

   localparam logic [15:0] A_BASE = 16'h0100;
   localparam logic [15:0] B_BASE = 16'h0200;
   localparam logic [15:0] C_BASE = 16'h0300;
   localparam logic [15:0] MATMUL = 16'h0400;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_TRIGGER,
      S_WAIT,
      S_RD_REQ,
      S_RD_WAIT,
      S_RD_OUT,
      S_DONE
   } state_t;

   function automatic int wpr(
      input int dim,
      input int bits,
      input int dataw
   );
      return (dim * bits) / dataw;
   endfunction

   function automatic bit wpr_exact(
      input int dim,
      input int bits,
      input int dataw
   );
      return ((dim * bits) % dataw == 0) && (dim * bits >= dataw);
   endfunction

endpackage

// File: rtl/tpu_seq_out_reg.sv
// tpu_seq_out_reg: one-entry valid/ready holding register for the
// C word stream; data and last stay stable until the consumer takes them.
module tpu_seq_out_reg #(
   parameter int DATAW = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DATAW-1:0] load_data,
   input  logic             load_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_last  <= load_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/tpu_host_sequencer.sv
// tpu_host_sequencer: streams A/B into the TPU, triggers MATMUL, reads C out.
// Optional TPU_SEQ_PERF_EN adds a saturating per-job cycle counter.
module tpu_host_sequencer
   import tpu_seq_pkg::*;
#(
   parameter int BITS_AB        = 8,
   parameter int BITS_C         = 16,
   parameter int DIM            = 8,
   parameter int ADDRW          = 16,
   parameter int DATAW          = 64,
   parameter int COMPUTE_CYCLES = 3 * DIM - 2,
   parameter int RD_LAT         = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             busy,
   output logic             done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_last,
   output logic             tpu_r_w,
   output logic [ADDRW-1:0] tpu_addr,
   output logic [DATAW-1:0] tpu_wdata,
   input  logic [DATAW-1:0] tpu_rdata
`ifdef TPU_SEQ_PERF_EN
   ,
   output logic [31:0]      perf_cycles
`endif
);

   localparam int WPR_AB = wpr(DIM, BITS_AB, DATAW);
   localparam int WPR_C  = wpr(DIM, BITS_C, DATAW);
   localparam int N_AB   = DIM * WPR_AB;
   localparam int N_C    = DIM * WPR_C;
   localparam int M1     = N_AB > N_C ? N_AB : N_C;
   localparam int M2     = M1 > COMPUTE_CYCLES ? M1 : COMPUTE_CYCLES;
   localparam int M3     = M2 > RD_LAT + 1 ? M2 : RD_LAT + 1;
   localparam int CW     = $clog2(M3 + 1);

   if (!wpr_exact(DIM, BITS_AB, DATAW) ||
       !wpr_exact(DIM, BITS_C, DATAW) ||
       COMPUTE_CYCLES < 2) begin : g_bad_cfg
      $error("tpu_host_sequencer: unsupported configuration");
   end

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [CW-1:0]    k, k_n;
   logic             r_w_n;
   logic [ADDRW-1:0] addr_n;
   logic [DATAW-1:0] wdata_n;
   logic             load;
   logic             accept;
   logic             hs;
   logic             last_in;

   assign busy     = (state != S_IDLE);
   assign done     = (state == S_DONE);
   assign in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
   assign accept   = in_valid && in_ready;
   assign hs       = out_valid && out_ready;
   assign last_in  = (k == CW'(N_C - 1));

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      k_n     = k;
      r_w_n   = 1'b0;
      addr_n  = '0;
      wdata_n = '0;
      load    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_LOAD_A;
               cnt_n   = '0;
               k_n     = '0;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            if (accept) begin
               r_w_n   = 1'b1;
               addr_n  = (state == S_LOAD_A ? ADDRW'(A_BASE)
                                            : ADDRW'(B_BASE))
                         + (ADDRW'(cnt) << 3);
               wdata_n = in_data;
               if (cnt == CW'(N_AB - 1)) begin
                  cnt_n   = '0;
                  state_n = (state == S_LOAD_A) ? S_LOAD_B : S_TRIGGER;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         S_TRIGGER: begin
            r_w_n   = 1'b1;
            addr_n  = ADDRW'(MATMUL);
            cnt_n   = '0;
            state_n = S_WAIT;
         end
         // TRIGGER plus WAIT span COMPUTE_CYCLES from trigger to read
         S_WAIT: begin
            if (cnt == CW'(COMPUTE_CYCLES - 2)) begin
               cnt_n   = '0;
               state_n = S_RD_REQ;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RD_REQ: begin
            addr_n  = ADDRW'(C_BASE) + (ADDRW'(k) << 3);
            cnt_n   = '0;
            state_n = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (cnt == CW'(RD_LAT)) begin
               load    = 1'b1;
               cnt_n   = '0;
               state_n = S_RD_OUT;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         S_RD_OUT: begin
            if (hs) begin
               if (last_in) begin
                  state_n = S_DONE;
               end else begin
                  k_n     = k + 1'b1;
                  state_n = S_RD_REQ;
               end
            end
         end
         S_DONE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         k         <= '0;
         tpu_r_w   <= 1'b0;
         tpu_addr  <= '0;
         tpu_wdata <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         k         <= k_n;
         tpu_r_w   <= r_w_n;
         tpu_addr  <= addr_n;
         tpu_wdata <= wdata_n;
      end
   end

   tpu_seq_out_reg #(
      .DATAW(DATAW)
   ) u_out (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_data(tpu_rdata),
      .load_last(last_in),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

`ifdef TPU_SEQ_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_cycles <= '0;
      end else if (state == S_IDLE && start) begin
         perf_cycles <= '0;
      end else if (state != S_IDLE && perf_cycles != '1) begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// tb_tpu_host_sequencer: scoreboard bench with a registered TPU read model;
// bus writes, C reads and C output words are popped from expectation queues.
module tb_tpu_host_sequencer;

   typedef struct packed {
      logic [15:0] a;
      logic [63:0] d;
   } wr_t;

   typedef struct packed {
      logic [63:0] d;
      logic        l;
   } c_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic        done;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic        tpu_r_w;
   logic [15:0] tpu_addr;
   logic [63:0] tpu_wdata;
   logic [63:0] tpu_rdata;
`ifdef TPU_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   int trig_cyc = 0;
   int last_perf_exp = 0;
   bit trig_seen = 0;
   bit stall_mode = 0;
   bit last_acc = 0;
   bit last_ov = 0;
   bit prev_ov = 0;
   bit prev_or = 0;
   bit prev_done = 0;
   logic [63:0] prev_od = '0;
   logic        prev_ol = 1'b0;
   logic [63:0] c_mem [16];

   wr_t         exp_wr[$];
   logic [15:0] exp_rd[$];
   c_t          exp_c[$];

   tpu_host_sequencer dut (
`ifdef TPU_SEQ_PERF_EN
      .perf_cycles(perf_cycles),
`endif
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .tpu_r_w   (tpu_r_w),
      .tpu_addr  (tpu_addr),
      .tpu_wdata (tpu_wdata),
      .tpu_rdata (tpu_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] rd_model(input logic [15:0] a);
      if (a >= 16'h0300 && a < 16'h0380) return c_mem[a[6:3]];
      return {48'hdead_0000_0000, a};
   endfunction

   // TPU slave: one-cycle registered read data
   always @(posedge clk) tpu_rdata <= rd_model(tpu_addr);

   task automatic monitor();
      wr_t         w;
      c_t          c;
      logic [15:0] ra;
      if (tpu_r_w) begin
         wr_cnt++;
         checks++;
         if (exp_wr.size() == 0) begin
            failures++;
            $display("FAIL bus_write unexpected addr=%h data=%h",
                     tpu_addr, tpu_wdata);
         end else begin
            w = exp_wr.pop_front();
            if (tpu_addr !== w.a || tpu_wdata !== w.d) begin
               failures++;
               $display("FAIL bus_write got addr=%h data=%h want addr=%h data=%h",
                        tpu_addr, tpu_wdata, w.a, w.d);
            end
         end
         if (tpu_addr == 16'h0400) begin
            trig_seen = 1;
            trig_cyc  = cyc;
         end
      end else if (tpu_addr !== 16'h0000) begin
         rd_cnt++;
         checks++;
         if (exp_rd.size() == 0) begin
            failures++;
            $display("FAIL bus_read unexpected addr=%h", tpu_addr);
         end else begin
            ra = exp_rd.pop_front();
            if (tpu_addr !== ra) begin
               failures++;
               $display("FAIL bus_read got addr=%h want %h", tpu_addr, ra);
            end
         end
         if (trig_seen) begin
            checks++;
            if (cyc - trig_cyc != 22) begin
               failures++;
               $display("FAIL trigger_to_read got %0d want 22",
                        cyc - trig_cyc);
            end
            trig_seen = 0;
         end
      end
      if (prev_ov && !prev_or) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== prev_od ||
             out_last !== prev_ol) begin
            failures++;
            $display("FAIL out_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     out_valid, out_data, out_last, prev_od, prev_ol);
         end
      end
      if (out_valid && out_ready) begin
         checks++;
         if (exp_c.size() == 0) begin
            failures++;
            $display("FAIL out_word unexpected data=%h", out_data);
         end else begin
            c = exp_c.pop_front();
            if (out_data !== c.d || out_last !== c.l) begin
               failures++;
               $display("FAIL out_word got d=%h l=%b want d=%h l=%b",
                        out_data, out_last, c.d, c.l);
            end
         end
      end
      if (done) begin
         checks++;
         if (prev_done) begin
            failures++;
            $display("FAIL done_width got 2+ cycles want 1");
         end
         done_cnt++;
         done_cyc = cyc;
      end
      prev_done = done;
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_od   = out_data;
      prev_ol   = out_last;
   endtask

   task automatic step();
      @(negedge clk);
      last_acc = rst_n && in_valid && in_ready;
      last_ov  = rst_n && out_valid;
      if (rst_n) begin
         monitor();
      end else begin
         prev_ov   = 0;
         prev_done = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      out_ready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic send_word(
      input logic [63:0] w,
      input logic [15:0] a,
      input bit          gaps
   );
      int  g;
      int  t;
      wr_t e;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
         in_valid = 0;
         in_data  = 64'(j);
         step();
      end
      in_valid = 1;
      in_data  = w;
      t = 0;
      do begin
         step();
         t++;
      end while (!last_acc && t < 100);
      checks++;
      if (!last_acc) begin
         failures++;
         $display("FAIL in_accept timeout addr=%h got none want accept", a);
      end else begin
         e.a = a;
         e.d = w;
         exp_wr.push_back(e);
      end
   endtask

   task automatic run_job(input bit gaps, input bit stall, input bit poke);
      int          base;
      int          s_cyc;
      int          t;
      bit          poked;
      logic [63:0] w;
      logic [15:0] a;
      c_t          c;
      wr_t         e;
      for (int k = 0; k < 16; k++) begin
         c_mem[k] = {$urandom, $urandom};
         c.d = c_mem[k];
         c.l = (k == 15);
         exp_c.push_back(c);
         exp_rd.push_back(16'h0300 + 16'(8 * k));
      end
      base  = done_cnt;
      start = 1;
      step();
      start = 0;
      s_cyc = cyc;
`ifdef TPU_SEQ_PERF_EN
      checks++;
      if (perf_cycles !== 32'd0) begin
         failures++;
         $display("FAIL perf_clear got %0d want 0", perf_cycles);
      end
`endif
      stall_mode = stall;
      for (int i = 0; i < 16; i++) begin
         w = gaps ? {$urandom, $urandom} : 64'(i);
         a = (i < 8 ? 16'h0100 : 16'h0200) + 16'(8 * (i % 8));
         if (poke && i == 10) start = 1;
         send_word(w, a, gaps);
         start = 0;
      end
      in_valid = 0;
      e.a = 16'h0400;
      e.d = 64'h0;
      exp_wr.push_back(e);
      t = 0;
      poked = 0;
      while (done_cnt == base && t < 4000) begin
         step();
         t++;
         if (poke && !poked && last_ov) begin
            start = 1;
            step();
            start = 0;
            poked = 1;
         end
      end
      checks++;
      if (done_cnt != base + 1) begin
         failures++;
         $display("FAIL done_count got %0d want %0d", done_cnt - base, 1);
      end
      checks++;
      if (exp_wr.size() != 0 || exp_rd.size() != 0 || exp_c.size() != 0) begin
         failures++;
         $display("FAIL leftovers got wr=%0d rd=%0d c=%0d want 0",
                  exp_wr.size(), exp_rd.size(), exp_c.size());
      end
      last_perf_exp = done_cyc - s_cyc + 1;
`ifdef TPU_SEQ_PERF_EN
      checks++;
      if (perf_cycles !== 32'(last_perf_exp)) begin
         failures++;
         $display("FAIL perf_count got %0d want %0d",
                  perf_cycles, last_perf_exp);
      end
`endif
      stall_mode = 0;
   endtask

   task automatic test_reset();
      rst_n      = 0;
      start      = 0;
      in_valid   = 0;
      in_data    = '0;
      out_ready  = 0;
      stall_mode = 0;
      repeat (3) step();
      rst_n    = 1;
      in_valid = 1;
      for (int i = 0; i < 10; i++) begin
         in_data = {$urandom, $urandom};
         step();
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if (done !== 1'b0) begin
         failures++; $display("FAIL reset_done got %b want 0", done);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++; $display("FAIL reset_in_ready got %b want 0", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
         failures++;
         $display("FAIL reset_out got v=%b l=%b want 0 0", out_valid, out_last);
      end
      checks++;
      if (out_data !== 64'h0) begin
         failures++; $display("FAIL reset_out_data got %h want 0", out_data);
      end
      checks++;
      if (tpu_r_w !== 1'b0 || tpu_addr !== 16'h0) begin
         failures++;
         $display("FAIL reset_bus got r_w=%b addr=%h want 0 0", tpu_r_w, tpu_addr);
      end
      checks++;
      if (tpu_wdata !== 64'h0) begin
         failures++; $display("FAIL reset_wdata got %h want 0", tpu_wdata);
      end
      checks++;
      if (wr_cnt != 0) begin
         failures++; $display("FAIL idle_writes got %0d want 0", wr_cnt);
      end
`ifdef TPU_SEQ_PERF_EN
      checks++;
      if (perf_cycles !== 32'd0) begin
         failures++; $display("FAIL reset_perf got %0d want 0", perf_cycles);
      end
`endif
      in_valid = 0;
      step();
   endtask

   task automatic test_basic();
      run_job(0, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_stalls();
      run_job(1, 1, 0);
      repeat (3) step();
      run_job(1, 1, 0);
      repeat (3) step();
   endtask

   task automatic test_start_ignored();
      int w0;
      int d0;
      run_job(0, 1, 1);
      w0 = wr_cnt;
      d0 = done_cnt;
      repeat (6) step();
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || wr_cnt != w0 || done_cnt != d0) begin
         failures++;
         $display("FAIL start_ignored got busy=%b rdy=%b wr=%0d want 0 0 %0d",
                  busy, in_ready, wr_cnt, w0);
      end
   endtask

   task automatic test_reset_mid();
      int  w0;
      int  r0;
      wr_t e;
      for (int sc = 0; sc < 2; sc++) begin
         start = 1;
         step();
         start = 0;
         for (int i = 0; i < (sc == 0 ? 16 : 3); i++)
            send_word(64'(i + 100),
                      (i < 8 ? 16'h0100 : 16'h0200) + 16'(8 * (i % 8)), 0);
         in_valid = 0;
         if (sc == 0) begin
            e.a = 16'h0400;
            e.d = 64'h0;
            exp_wr.push_back(e);
            repeat (6) step();
         end
         rst_n = 0;
         #1;
         checks++;
         if (tpu_r_w !== 1'b0 || tpu_addr !== 16'h0 ||
             busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_bus sc=%0d got r_w=%b addr=%h busy=%b want 0",
                     sc, tpu_r_w, tpu_addr, busy);
         end
         exp_wr.delete();
         exp_rd.delete();
         exp_c.delete();
         trig_seen = 0;
         step();
         step();
         rst_n = 1;
         w0 = wr_cnt;
         r0 = rd_cnt;
         repeat (30) step();
         checks++;
         if (wr_cnt != w0 || rd_cnt != r0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_abort sc=%0d got wr=%0d rd=%0d busy=%b want 0 0 0",
                     sc, wr_cnt - w0, rd_cnt - r0, busy);
         end
      end
      run_job(1, 0, 0);
      repeat (3) step();
   endtask

   task automatic test_back_to_back();
      run_job(0, 0, 0);
      run_job(1, 1, 0);
      repeat (3) step();
   endtask

`ifdef TPU_SEQ_PERF_EN
   task automatic test_perf();
      run_job(0, 0, 0);
      repeat (5) step();
      checks++;
      if (perf_cycles !== 32'(last_perf_exp)) begin
         failures++;
         $display("FAIL perf_hold got %0d want %0d", perf_cycles, last_perf_exp);
      end
      run_job(0, 0, 0);
      run_job(0, 0, 0);
      repeat (3) step();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stalls();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
`ifdef TPU_SEQ_PERF_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
